// File: rtl/ccip_rsp_model_pkg.sv
// Shared types for the CCI-P channel-0 read responder model: the interface structs,
// the queued request entry, the FSM states and the cl_len helper functions.
package ccip_rsp_model_pkg;

  typedef logic [1:0] t_ccip_vc;
  typedef logic [1:0] t_ccip_cl_len;
  typedef logic [3:0] t_ccip_c0_req;
  typedef logic [3:0] t_ccip_c0_rsp;

  localparam t_ccip_vc     eVC_VA        = 2'd0;
  localparam t_ccip_vc     eVC_VH0       = 2'd2;
  localparam t_ccip_c0_req eREQ_RDLINE_I = 4'h0;
  localparam t_ccip_c0_req eREQ_RDLINE_S = 4'h1;
  localparam t_ccip_c0_rsp eRSP_RDLINE   = 4'h0;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    t_ccip_cl_len cl_len;
    t_ccip_c0_req req_type;
    logic [41:0]  address;
    logic [15:0]  mdata;
  } t_ccip_c0_req_hdr;

  typedef struct packed {
    t_ccip_c0_req_hdr hdr;
    logic             valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         hit_miss;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c0_rsp_hdr;

  typedef struct packed {
    t_ccip_c0_rsp_hdr hdr;
    logic [511:0]     data;
    logic             rspValid;
    logic             mmioRdValid;
    logic             mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic [41:0]  address;
    logic [15:0]  mdata;
    t_ccip_cl_len cl_len;
    t_ccip_vc     vc_sel;
  } t_rd_req_entry;

  typedef enum logic [1:0] {IDLE, WAIT, SEND} t_rsp_state;

  // The reserved encoding 2 is served as a 4-line burst.
  function automatic logic [2:0] cl_lines(input t_ccip_cl_len cl_len);
    case (cl_len)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] addr_lo, input t_ccip_cl_len cl_len);
    case (cl_len)
      2'd0:    return 1'b0;
      2'd1:    return addr_lo[0];
      default: return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/ccip_req_fifo.sv
// Generic synchronous FIFO; free_nxt is the free-entry count after this cycle's push/pop.
module ccip_req_fifo #(
  parameter type         T_ENTRY = logic,
  parameter int unsigned DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  T_ENTRY                   din,
  input  logic                     pop,
  output T_ENTRY                   dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   free_nxt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

  T_ENTRY        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  // A pop on a full queue frees its slot first, so a same-cycle push still lands.
  always_comb begin
    do_pop   = pop && (cnt_q != '0);
    do_push  = push && ((cnt_q != DEPTH_C) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    free_nxt = DEPTH_C - cnt_d;
    empty    = (cnt_q == '0);
    full     = (cnt_q == DEPTH_C);
    dout     = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/ccip_host_rd_responder.sv
// Host-side CCI-P c0 read responder model: queues RDLINE requests and returns
// in-order response beats from a preloadable line memory after a fixed latency.
module ccip_host_rd_responder
  import ccip_rsp_model_pkg::*;
#(
  parameter int unsigned MEM_LINES_LOG2 = 10,
  parameter int unsigned REQ_FIFO_DEPTH = 16,
  parameter int unsigned ALMFULL_SLACK  = 8,
  parameter int unsigned RSP_LATENCY    = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  t_if_ccip_c0_Tx            c0tx,
  output logic                      c0TxAlmFull,
  output t_if_ccip_c0_Rx            c0rx,
  input  logic                      preload_we,
  input  logic [MEM_LINES_LOG2-1:0] preload_addr,
  input  logic [511:0]              preload_data,
  output logic                      err_overflow,
  output logic                      err_misaligned,
  output logic                      err_bad_req
);

  localparam int unsigned AW = MEM_LINES_LOG2;
  localparam int unsigned FW = $clog2(REQ_FIFO_DEPTH) + 1;
  localparam logic [FW-1:0] SLACK_C = FW'(ALMFULL_SLACK);
  localparam logic [7:0]    LAT_C   = 8'(RSP_LATENCY);

  t_rd_req_entry  push_entry, head;
  logic           type_ok, push, pop, fifo_empty, fifo_full;
  logic [FW-1:0]  free_nxt;
  t_rsp_state     state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [1:0]     beat_q, beat_d;
  logic [AW-1:0]  base_q, base_d, rd_idx;
  logic [15:0]    mdata_q, mdata_d;
  logic [2:0]     lines_q, lines_d;
  t_ccip_vc       vc_q, vc_d;
  t_if_ccip_c0_Rx rsp_q, rsp_d;
  logic           almfull_q, almfull_d;
  logic           err_overflow_q, err_overflow_d;
  logic           err_misaligned_q, err_misaligned_d;
  logic           err_bad_req_q, err_bad_req_d;
  logic [511:0]   mem_q [2**AW];
  logic           unused_ok;

  assign unused_ok = ^head.address[41:AW];

  ccip_req_fifo #(
    .T_ENTRY (t_rd_req_entry),
    .DEPTH   (REQ_FIFO_DEPTH)
  ) u_req_fifo (
    .clk      (clk),
    .rst_n    (reset_n),
    .push     (push),
    .din      (push_entry),
    .pop      (pop),
    .dout     (head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .free_nxt (free_nxt)
  );

  always_comb begin
    type_ok    = (c0tx.hdr.req_type == eREQ_RDLINE_I) || (c0tx.hdr.req_type == eREQ_RDLINE_S);
    push       = c0tx.valid && type_ok;
    push_entry = '{address: c0tx.hdr.address, mdata: c0tx.hdr.mdata,
                   cl_len: c0tx.hdr.cl_len, vc_sel: c0tx.hdr.vc_sel};
    err_overflow_d   = err_overflow_q | (push & fifo_full & ~pop);
    err_bad_req_d    = err_bad_req_q | (c0tx.valid & ~type_ok) | (push & (c0tx.hdr.cl_len == 2'd2));
    err_misaligned_d = err_misaligned_q | (push & is_misaligned(c0tx.hdr.address[1:0], c0tx.hdr.cl_len));
    almfull_d        = (free_nxt <= SLACK_C);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    base_d  = base_q;
    mdata_d = mdata_q;
    lines_d = lines_q;
    vc_d    = vc_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        base_d  = head.address[AW-1:0];
        mdata_d = head.mdata;
        lines_d = cl_lines(head.cl_len);
        vc_d    = head.vc_sel;
        cnt_d   = LAT_C;
        beat_d  = '0;
        state_d = (RSP_LATENCY > 0) ? WAIT : SEND;
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = SEND;
      end
      SEND: begin
        if ({1'b0, beat_q} == lines_q - 3'd1) state_d = IDLE;
        else                                  beat_d  = beat_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response is built from next-state values so the registered beat lines up with SEND.
  always_comb begin
    rsp_d  = '0;
    rd_idx = base_d + AW'(beat_d);
    if (state_d == SEND) begin
      rsp_d.rspValid      = 1'b1;
      rsp_d.hdr.resp_type = eRSP_RDLINE;
      rsp_d.hdr.mdata     = mdata_d;
      rsp_d.hdr.cl_num    = beat_d;
      rsp_d.hdr.vc_used   = (vc_d == eVC_VA) ? eVC_VH0 : vc_d;
      rsp_d.data          = mem_q[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q            <= '0;
      beat_q           <= '0;
      rsp_q            <= '0;
      almfull_q        <= 1'b0;
      err_overflow_q   <= 1'b0;
      err_misaligned_q <= 1'b0;
      err_bad_req_q    <= 1'b0;
    end else begin
      cnt_q            <= cnt_d;
      beat_q           <= beat_d;
      rsp_q            <= rsp_d;
      almfull_q        <= almfull_d;
      err_overflow_q   <= err_overflow_d;
      err_misaligned_q <= err_misaligned_d;
      err_bad_req_q    <= err_bad_req_d;
    end
  end

  always_ff @(posedge clk) begin
    base_q  <= base_d;
    mdata_q <= mdata_d;
    lines_q <= lines_d;
    vc_q    <= vc_d;
  end

  // A same-edge preload to the line being read leaves the old data in the beat.
  always_ff @(posedge clk) begin
    if (preload_we) mem_q[preload_addr] <= preload_data;
  end

  assign c0rx           = rsp_q;
  assign c0TxAlmFull    = almfull_q;
  assign err_overflow   = err_overflow_q;
  assign err_misaligned = err_misaligned_q;
  assign err_bad_req    = err_bad_req_q;

endmodule

// File: tb/tb_ccip_host_rd_responder.sv
// Directed bench for ccip_host_rd_responder: three instances (latency 4, 0 and 40)
// share stimulus; each scenario checks the instance suited to it.
module tb_ccip_host_rd_responder;
  import ccip_rsp_model_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n;
  t_if_ccip_c0_Tx c0tx;
  logic           preload_we;
  logic [9:0]     preload_addr;
  logic [511:0]   preload_data;

  t_if_ccip_c0_Rx rx_a, rx_z, rx_s;
  logic af_a, af_z, af_s;
  logic ovf_a, ovf_z, ovf_s;
  logic mis_a, mis_z, mis_s;
  logic bad_a, bad_z, bad_s;

  int n_cmp = 0;
  int n_bad = 0;

  ccip_host_rd_responder #(.RSP_LATENCY(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .c0tx(c0tx), .c0TxAlmFull(af_a), .c0rx(rx_a),
    .preload_we(preload_we), .preload_addr(preload_addr), .preload_data(preload_data),
    .err_overflow(ovf_a), .err_misaligned(mis_a), .err_bad_req(bad_a));

  ccip_host_rd_responder #(.RSP_LATENCY(0)) dut_z (
    .clk(clk), .reset_n(reset_n), .c0tx(c0tx), .c0TxAlmFull(af_z), .c0rx(rx_z),
    .preload_we(preload_we), .preload_addr(preload_addr), .preload_data(preload_data),
    .err_overflow(ovf_z), .err_misaligned(mis_z), .err_bad_req(bad_z));

  ccip_host_rd_responder #(.RSP_LATENCY(40)) dut_s (
    .clk(clk), .reset_n(reset_n), .c0tx(c0tx), .c0TxAlmFull(af_s), .c0rx(rx_s),
    .preload_we(preload_we), .preload_addr(preload_addr), .preload_data(preload_data),
    .err_overflow(ovf_s), .err_misaligned(mis_s), .err_bad_req(bad_s));

  function automatic logic [511:0] pat(input int k);
    logic [31:0] w;
    w = (k * 32'h9E37_79B9) ^ 32'h5A5A_C3C3;
    return {8{w, ~w}};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    tick;
    tick;
    reset_n = 1'b1;
    tick;
  endtask

  task automatic preload(input logic [9:0] a, input logic [511:0] d);
    preload_we   = 1'b1;
    preload_addr = a;
    preload_data = d;
    tick;
    preload_we   = 1'b0;
  endtask

  task automatic send_req(input logic [41:0] addr, input logic [15:0] md, input logic [1:0] cl,
                          input logic [3:0] rt, input logic [1:0] vc);
    c0tx.valid        = 1'b1;
    c0tx.hdr.address  = addr;
    c0tx.hdr.mdata    = md;
    c0tx.hdr.cl_len   = cl;
    c0tx.hdr.req_type = rt;
    c0tx.hdr.vc_sel   = vc;
    tick;
    c0tx.valid        = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    n_cmp++; if (rx_a !== '0) begin n_bad++; $display("FAIL reset_c0rx: got %h want 0", rx_a); end
    n_cmp++; if (af_a !== 1'b0) begin n_bad++; $display("FAIL reset_almfull: got %b want 0", af_a); end
    n_cmp++; if ({ovf_a, mis_a, bad_a} !== 3'b000) begin n_bad++; $display("FAIL reset_errs: got %b want 000", {ovf_a, mis_a, bad_a}); end
    n_cmp++; if ({rx_z.rspValid, rx_s.rspValid} !== 2'b00) begin n_bad++; $display("FAIL reset_valid_zs: got %b want 00", {rx_z.rspValid, rx_s.rspValid}); end
  endtask

  task automatic test_single;
    do_reset;
    send_req(42'h10, 16'h005A, 2'd0, 4'h0, 2'd0);
    for (int i = 1; i <= 4; i++) begin
      tick;
      n_cmp++; if (rx_a.rspValid !== 1'b0) begin n_bad++; $display("FAIL single_early%0d: got %b want 0", i, rx_a.rspValid); end
    end
    tick;
    n_cmp++; if (rx_a.rspValid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", rx_a.rspValid); end
    n_cmp++; if (rx_a.hdr.mdata !== 16'h005A) begin n_bad++; $display("FAIL single_mdata: got %h want 005a", rx_a.hdr.mdata); end
    n_cmp++; if (rx_a.hdr.cl_num !== 2'd0) begin n_bad++; $display("FAIL single_clnum: got %0d want 0", rx_a.hdr.cl_num); end
    n_cmp++; if (rx_a.data !== pat(16'h10)) begin n_bad++; $display("FAIL single_data: got %h want %h", rx_a.data, pat(16'h10)); end
    n_cmp++; if ({rx_a.hdr.resp_type, rx_a.hdr.vc_used, rx_a.hdr.hit_miss} !== {4'h0, 2'd2, 1'b0}) begin
      n_bad++; $display("FAIL single_hdr: got %h/%0d/%b want 0/2/0", rx_a.hdr.resp_type, rx_a.hdr.vc_used, rx_a.hdr.hit_miss);
    end
    tick;
    n_cmp++; if (rx_a.rspValid !== 1'b0) begin n_bad++; $display("FAIL single_end: got %b want 0", rx_a.rspValid); end
  endtask

  task automatic test_burst4;
    do_reset;
    send_req(42'h20, 16'hBEEF, 2'd3, 4'h1, 2'd1);
    n_cmp++; if ({mis_a, bad_a} !== 2'b00) begin n_bad++; $display("FAIL burst4_errs: got %b want 00", {mis_a, bad_a}); end
    repeat (4) tick;
    for (int b = 0; b < 4; b++) begin
      tick;
      n_cmp++;
      if ({rx_a.rspValid, rx_a.hdr.cl_num, rx_a.hdr.mdata, rx_a.hdr.vc_used} !== {1'b1, 2'(b), 16'hBEEF, 2'd1}) begin
        n_bad++; $display("FAIL burst4_hdr%0d: got v%b cl%0d md%h vc%0d want v1 cl%0d mdbeef vc1",
                          b, rx_a.rspValid, rx_a.hdr.cl_num, rx_a.hdr.mdata, rx_a.hdr.vc_used, b);
      end
      n_cmp++; if (rx_a.data !== pat(32 + b)) begin n_bad++; $display("FAIL burst4_data%0d: got %h want %h", b, rx_a.data, pat(32 + b)); end
    end
    tick;
    n_cmp++; if (rx_a.rspValid !== 1'b0) begin n_bad++; $display("FAIL burst4_end: got %b want 0", rx_a.rspValid); end
  endtask

  task automatic test_misaligned_wrap;
    do_reset;
    send_req(42'h3, 16'h0033, 2'd1, 4'h0, 2'd0);
    n_cmp++; if (mis_a !== 1'b1) begin n_bad++; $display("FAIL misal_flag: got %b want 1", mis_a); end
    repeat (4) tick;
    for (int b = 0; b < 2; b++) begin
      tick;
      n_cmp++; if ({rx_a.rspValid, rx_a.data} !== {1'b1, pat(3 + b)}) begin
        n_bad++; $display("FAIL misal_beat%0d: got v%b %h want v1 %h", b, rx_a.rspValid, rx_a.data, pat(3 + b));
      end
    end
    tick;
    send_req(42'h3FF, 16'h0044, 2'd1, 4'h0, 2'd0);
    repeat (4) tick;
    tick;
    n_cmp++; if ({rx_a.rspValid, rx_a.data} !== {1'b1, pat(1023)}) begin
      n_bad++; $display("FAIL wrap_beat0: got v%b %h want v1 %h", rx_a.rspValid, rx_a.data, pat(1023));
    end
    tick;
    n_cmp++; if ({rx_a.rspValid, rx_a.hdr.cl_num, rx_a.data} !== {1'b1, 2'd1, pat(0)}) begin
      n_bad++; $display("FAIL wrap_beat1: got v%b cl%0d %h want v1 cl1 %h", rx_a.rspValid, rx_a.hdr.cl_num, rx_a.data, pat(0));
    end
  endtask

  task automatic test_bad_req;
    int seen;
    do_reset;
    send_req(42'h10, 16'h0011, 2'd0, 4'h4, 2'd0);
    n_cmp++; if ({bad_a, mis_a} !== 2'b10) begin n_bad++; $display("FAIL badtype_flags: got %b want 10", {bad_a, mis_a}); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (rx_a.rspValid === 1'b1) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL badtype_dropped: got %0d beats want 0", seen); end
    do_reset;
    send_req(42'h24, 16'h0066, 2'd2, 4'h0, 2'd0);
    n_cmp++; if ({bad_a, mis_a} !== 2'b10) begin n_bad++; $display("FAIL cl2_flags: got %b want 10", {bad_a, mis_a}); end
    repeat (4) tick;
    for (int b = 0; b < 4; b++) begin
      tick;
      n_cmp++; if ({rx_a.rspValid, rx_a.hdr.cl_num, rx_a.data} !== {1'b1, 2'(b), pat(36 + b)}) begin
        n_bad++; $display("FAIL cl2_beat%0d: got v%b cl%0d %h want v1 %h", b, rx_a.rspValid, rx_a.hdr.cl_num, rx_a.data, pat(36 + b));
      end
    end
  endtask

  task automatic test_zero_latency;
    do_reset;
    send_req(42'h10, 16'h00A1, 2'd0, 4'h0, 2'd0);
    n_cmp++; if (rx_z.rspValid !== 1'b0) begin n_bad++; $display("FAIL lat0_t1: got %b want 0", rx_z.rspValid); end
    send_req(42'h11, 16'h00A2, 2'd0, 4'h0, 2'd0);
    n_cmp++; if ({rx_z.rspValid, rx_z.hdr.mdata, rx_z.data} !== {1'b1, 16'h00A1, pat(16)}) begin
      n_bad++; $display("FAIL lat0_t2: got v%b md%h want v1 mda1", rx_z.rspValid, rx_z.hdr.mdata);
    end
    tick;
    n_cmp++; if (rx_z.rspValid !== 1'b0) begin n_bad++; $display("FAIL lat0_t3: got %b want 0", rx_z.rspValid); end
    tick;
    n_cmp++; if ({rx_z.rspValid, rx_z.hdr.mdata, rx_z.data} !== {1'b1, 16'h00A2, pat(17)}) begin
      n_bad++; $display("FAIL lat0_t4: got v%b md%h want v1 mda2", rx_z.rspValid, rx_z.hdr.mdata);
    end
    tick;
    n_cmp++; if (rx_z.rspValid !== 1'b0) begin n_bad++; $display("FAIL lat0_t5: got %b want 0", rx_z.rspValid); end
  endtask

  // First request goes straight into service; the next 16 fill the queue; the 18th is dropped.
  task automatic test_almfull_overflow;
    int n;
    do_reset;
    for (int i = 0; i < 18; i++) begin
      send_req(42'(64 + i), 16'(256 + i), 2'd0, 4'h0, 2'd0);
      if (i == 7) begin
        n_cmp++; if (af_s !== 1'b0) begin n_bad++; $display("FAIL almfull_7q: got %b want 0", af_s); end
      end
      if (i == 8) begin
        n_cmp++; if (af_s !== 1'b1) begin n_bad++; $display("FAIL almfull_8q: got %b want 1", af_s); end
      end
      if (i == 16) begin
        n_cmp++; if (ovf_s !== 1'b0) begin n_bad++; $display("FAIL ovf_before: got %b want 0", ovf_s); end
      end
      if (i == 17) begin
        n_cmp++; if (ovf_s !== 1'b1) begin n_bad++; $display("FAIL ovf_after: got %b want 1", ovf_s); end
      end
    end
    n = 0;
    for (int c = 0; c < 1000; c++) begin
      tick;
      if (rx_s.rspValid === 1'b1) begin
        if (n < 17) begin
          n_cmp++; if ({rx_s.hdr.mdata, rx_s.data} !== {16'(256 + n), pat(64 + n)}) begin
            n_bad++; $display("FAIL order_rsp%0d: got md%h want md%h", n, rx_s.hdr.mdata, 16'(256 + n));
          end
        end
        n++;
      end
    end
    n_cmp++; if (n != 17) begin n_bad++; $display("FAIL overflow_count: got %0d responses want 17", n); end
  endtask

  task automatic test_reset_mid_burst;
    int seen, lat;
    do_reset;
    send_req(42'h20, 16'h0077, 2'd3, 4'h0, 2'd0);
    for (int i = 0; i < 9; i++) send_req(42'(80 + i), 16'(512 + i), 2'd0, 4'h0, 2'd0);
    n_cmp++; if (af_s !== 1'b1) begin n_bad++; $display("FAIL midrst_almfull_pre: got %b want 1", af_s); end
    repeat (31) tick;
    tick;
    n_cmp++; if ({rx_s.rspValid, rx_s.hdr.cl_num} !== {1'b1, 2'd0}) begin
      n_bad++; $display("FAIL midrst_beat0: got v%b cl%0d want v1 cl0", rx_s.rspValid, rx_s.hdr.cl_num);
    end
    tick;
    n_cmp++; if ({rx_s.rspValid, rx_s.hdr.cl_num, rx_s.data} !== {1'b1, 2'd1, pat(33)}) begin
      n_bad++; $display("FAIL midrst_beat1: got v%b cl%0d want v1 cl1", rx_s.rspValid, rx_s.hdr.cl_num);
    end
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (rx_s !== '0) begin n_bad++; $display("FAIL midrst_c0rx: got v%b want all zero", rx_s.rspValid); end
    n_cmp++; if (af_s !== 1'b0) begin n_bad++; $display("FAIL midrst_almfull: got %b want 0", af_s); end
    tick;
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick;
      if (rx_s.rspValid === 1'b1) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL midrst_quiet: got %0d beats want 0", seen); end
    send_req(42'h10, 16'h0099, 2'd0, 4'h0, 2'd0);
    lat = 0;
    for (int i = 1; i <= 100 && lat == 0; i++) begin
      tick;
      if (rx_s.rspValid === 1'b1) lat = i;
    end
    n_cmp++; if (lat != 41) begin n_bad++; $display("FAIL midrst_relat: got %0d cycles want 41", lat); end
    n_cmp++; if ({rx_s.hdr.mdata, rx_s.data} !== {16'h0099, pat(16)}) begin
      n_bad++; $display("FAIL midrst_redata: got md%h want md0099", rx_s.hdr.mdata);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n      = 1'b0;
    c0tx         = '0;
    preload_we   = 1'b0;
    preload_addr = '0;
    preload_data = '0;
    tick;
    for (int k = 0; k < 128; k++) preload(10'(k), pat(k));
    preload(10'h3FF, pat(1023));
    test_reset;
    test_single;
    test_burst4;
    test_misaligned_wrap;
    test_bad_req;
    test_zero_latency;
    test_almfull_overflow;
    test_reset_mid_burst;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
